// File: rtl/can_pkg.sv
// Shared field codes, field lengths and data-length helper for the CAN frame
// window controller.
package can_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARB  = 3'd1,
      ST_CTRL = 3'd2,
      ST_DATA = 3'd3,
      ST_CRC  = 3'd4,
      ST_TAIL = 3'd5
   } field_e;

   localparam int FCNT_W = 8;

   localparam logic [FCNT_W-1:0] ARB_STD_LEN = FCNT_W'(12);
   localparam logic [FCNT_W-1:0] ARB_EXT_LEN = FCNT_W'(32);
   localparam logic [FCNT_W-1:0] CTRL_LEN    = FCNT_W'(6);
   localparam logic [FCNT_W-1:0] CRC_LEN     = FCNT_W'(15);

   // Number of destuffed DATA bits for a given DLC; remote frames carry none.
   function automatic logic [FCNT_W-1:0] data_bits(input logic [3:0] dlc,
                                                   input logic       rtr,
                                                   input int         max_bytes);
      logic [FCNT_W-1:0] n;
      if (rtr) return '0;
      n = (int'({28'd0, dlc}) < max_bytes) ? FCNT_W'(dlc) : FCNT_W'(max_bytes);
      return n << 3;
   endfunction

endpackage

// File: rtl/stuff_run_cnt.sv
// Run-length tracker for bit stuffing: flags the bit following five equal bits.
module stuff_run_cnt (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic load,
   input  logic en,
   input  logic rx,
   output logic stuff
);

   logic [2:0] run_q;
   logic       prev_q;

   assign stuff = (run_q == 3'd5);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         run_q  <= '0;
         prev_q <= 1'b0;
      end else if (load) begin
         // SOF is always dominant and opens the first run
         run_q  <= 3'd1;
         prev_q <= 1'b0;
      end else if (en) begin
         run_q  <= (stuff || (rx != prev_q)) ? 3'd1 : run_q + 3'd1;
         prev_q <= rx;
      end
   end

endmodule

// File: rtl/stuff_window_ctrl.sv
// Tracks CAN frame fields on the sample-point clock and marks the stuff area.
// Define STUFF_EXT_ID_EN to decode extended (29-bit ID) frames; otherwise they abort.
module stuff_window_ctrl
   import can_pkg::*;
#(
   parameter int TAIL_BITS = 10,
   parameter int MAX_BYTES = 8
) (
   input  logic       SP,
   input  logic       reset,
   input  logic       RX,
   input  logic       STF_ERR,
   output logic       F_STF,
   output logic       STF_SKIP,
   output logic       BIT_EN,
   output logic [2:0] FIELD,
   output logic [3:0] DLC,
   output logic       IDE,
   output logic       FRAME_DONE
);

   localparam logic [FCNT_W-1:0] TAIL_LAST = FCNT_W'(TAIL_BITS - 1);

   field_e            state_q, state_d, field_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d, dbits;
   logic [3:0]        dlc_d, dlc_sh;
   logic              ide_d, rtr_q, rtr_d, ext_q, ext_d;
   logic              f_stf_d, skip_d, bit_en_d, done_d;
   logic              run_load, run_en, run_clr, stuff;

   stuff_run_cnt u_run (
      .clk   (SP),
      .reset (reset),
      .clr   (run_clr),
      .load  (run_load),
      .en    (run_en),
      .rx    (RX),
      .stuff (stuff)
   );

   assign dlc_sh  = {DLC[2:0], RX};
   assign dbits   = data_bits(DLC, rtr_q, MAX_BYTES);
   assign run_clr = ~STF_ERR;

   always_ff @(posedge SP) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         fcnt_q     <= '0;
         rtr_q      <= 1'b0;
         ext_q      <= 1'b0;
         DLC        <= '0;
         IDE        <= 1'b0;
         F_STF      <= 1'b1;
         STF_SKIP   <= 1'b0;
         BIT_EN     <= 1'b0;
         FIELD      <= ST_IDLE;
         FRAME_DONE <= 1'b0;
      end else begin
         state_q    <= state_d;
         fcnt_q     <= fcnt_d;
         rtr_q      <= rtr_d;
         ext_q      <= ext_d;
         DLC        <= dlc_d;
         IDE        <= ide_d;
         F_STF      <= f_stf_d;
         STF_SKIP   <= skip_d;
         BIT_EN     <= bit_en_d;
         FIELD      <= field_d;
         FRAME_DONE <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      dlc_d    = DLC;
      ide_d    = IDE;
      rtr_d    = rtr_q;
      ext_d    = ext_q;
      field_d  = ST_IDLE;
      f_stf_d  = 1'b1;
      skip_d   = 1'b0;
      bit_en_d = 1'b0;
      done_d   = 1'b0;
      run_load = 1'b0;
      run_en   = 1'b0;

      if (!STF_ERR) begin
         state_d = ST_IDLE;
         fcnt_d  = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: if (!RX) begin
               state_d  = ST_ARB;
               fcnt_d   = '0;
               dlc_d    = '0;
               ide_d    = 1'b0;
               rtr_d    = 1'b0;
               ext_d    = 1'b0;
               run_load = 1'b1;
               bit_en_d = 1'b1;
               f_stf_d  = 1'b0;
            end
            ST_TAIL: begin
               field_d  = ST_TAIL;
               bit_en_d = 1'b1;
               if (fcnt_q == TAIL_LAST) begin
                  state_d = ST_IDLE;
                  fcnt_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  fcnt_d  = fcnt_q + 1'b1;
               end
            end
            ST_ARB, ST_CTRL, ST_DATA, ST_CRC: begin
               run_en  = 1'b1;
               field_d = state_q;
               f_stf_d = 1'b0;
               if (stuff) begin
                  skip_d = 1'b1;
               end else begin
                  bit_en_d = 1'b1;
                  fcnt_d   = fcnt_q + 1'b1;
                  unique case (state_q)
                     ST_ARB: begin
                        // The bit after RTR/SRR is IDE: dominant means it is
                        // already the first control bit of a standard frame.
                        if (!ext_q && fcnt_q == ARB_STD_LEN) begin
                           if (!RX) begin
                              field_d = ST_CTRL;
                              state_d = ST_CTRL;
                              fcnt_d  = FCNT_W'(1);
                           end else begin
`ifdef STUFF_EXT_ID_EN
                              ext_d = 1'b1;
                              ide_d = 1'b1;
`else
                              state_d  = ST_IDLE;
                              fcnt_d   = '0;
                              field_d  = ST_IDLE;
                              f_stf_d  = 1'b1;
                              bit_en_d = 1'b0;
`endif
                           end
                        end else if (ext_q && fcnt_q == ARB_EXT_LEN - 1'b1) begin
                           rtr_d   = RX;
                           state_d = ST_CTRL;
                           fcnt_d  = '0;
                        end else if (!ext_q && fcnt_q == ARB_STD_LEN - 1'b1) begin
                           rtr_d = RX;
                        end
                     end
                     ST_CTRL: begin
                        if (fcnt_q >= FCNT_W'(2)) dlc_d = dlc_sh;
                        if (fcnt_q == CTRL_LEN - 1'b1) begin
                           fcnt_d  = '0;
                           state_d = (data_bits(dlc_sh, rtr_q, MAX_BYTES) == '0) ? ST_CRC : ST_DATA;
                        end
                     end
                     ST_DATA: if (fcnt_q == dbits - 1'b1) begin
                        state_d = ST_CRC;
                        fcnt_d  = '0;
                     end
                     ST_CRC: if (fcnt_q == CRC_LEN) begin
                        // CRC done and no stuff bit pending: this is tail bit 0
                        field_d = ST_TAIL;
                        f_stf_d = 1'b1;
                        if (TAIL_LAST == '0) begin
                           state_d = ST_IDLE;
                           fcnt_d  = '0;
                           done_d  = 1'b1;
                        end else begin
                           state_d = ST_TAIL;
                           fcnt_d  = FCNT_W'(1);
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: begin
               state_d = ST_IDLE;
               fcnt_d  = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stuff_window_ctrl.sv
// Directed bench for stuff_window_ctrl: builds destuffed frames, stuffs them on the fly
// and checks field bit counts, stuff flags, aborts and reset behaviour.
module tb_stuff_window_ctrl;

   logic       SP = 1'b0;
   logic       reset, RX, STF_ERR;
   logic       F_STF, STF_SKIP, BIT_EN, IDE, FRAME_DONE;
   logic [2:0] FIELD;
   logic [3:0] DLC;

   int passed = 0, total = 0;

   logic bits[$];
   int   cnt[8];
   int   skip_cnt, done_cnt, fstf0, n_stuff, done_at, dcount, tcount, nbits;
   logic arm, aborted, in_stream, ab_rst;
   logic [3:0] ab_fld;
   logic [2:0] ab_field, at5_field;
   logic [3:0] ab_dlc;
   logic ab_fstf, ab_biten, ab_skip, ab_ide, ab_done;
   logic at4_skip, at5_skip, at5_biten;

   stuff_window_ctrl dut (
      .SP         (SP),
      .reset      (reset),
      .RX         (RX),
      .STF_ERR    (STF_ERR),
      .F_STF      (F_STF),
      .STF_SKIP   (STF_SKIP),
      .BIT_EN     (BIT_EN),
      .FIELD      (FIELD),
      .DLC        (DLC),
      .IDE        (IDE),
      .FRAME_DONE (FRAME_DONE)
   );

   always #5 SP = ~SP;

   task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task push(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) bits.push_back(v[i]);
   endtask

   task build_std(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                  input int nbytes, input logic [63:0] data, input logic [14:0] crc);
      push(64'd0, 1);
      push({53'd0, id}, 11);
      push({63'd0, rtr}, 1);
      push(64'd0, 2);
      push({60'd0, dlc}, 4);
      push(data, nbytes * 8);
      push({49'd0, crc}, 15);
   endtask

   task build_ext(input logic [10:0] ida, input logic [17:0] idb, input logic [3:0] dlc,
                  input int nbytes, input logic [63:0] data, input logic [14:0] crc);
      push(64'd0, 1);
      push({53'd0, ida}, 11);
      push(64'd3, 2);
      push({46'd0, idb}, 18);
      push(64'd0, 3);
      push({60'd0, dlc}, 4);
      push(data, nbytes * 8);
      push({49'd0, crc}, 15);
   endtask

   task drive_one(input logic b);
      @(negedge SP);
      RX      = b;
      STF_ERR = !(arm && !ab_rst);
      reset   = arm && ab_rst;
      @(posedge SP);
      #1;
      if (BIT_EN) cnt[FIELD]++;
      if (STF_SKIP) skip_cnt++;
      if (FRAME_DONE) done_cnt++;
      if (!F_STF) fstf0++;
      if (FRAME_DONE && !in_stream && done_at < 0) done_at = tcount;
      if (in_stream && dcount == 4) at4_skip = STF_SKIP;
      if (in_stream && dcount == 5) begin
         at5_skip  = STF_SKIP;
         at5_biten = BIT_EN;
         at5_field = FIELD;
      end
      if (arm) begin
         ab_field = FIELD; ab_fstf = F_STF; ab_biten = BIT_EN; ab_skip = STF_SKIP;
         ab_dlc   = DLC;   ab_ide  = IDE;   ab_done  = FRAME_DONE;
         aborted  = 1'b1;  arm     = 1'b0;
      end else if (in_stream) begin
         if ({1'b0, FIELD} == ab_fld) arm = 1'b1;
         if (F_STF) aborted = 1'b1;
      end
      dcount++;
   endtask

   // Drives the queued frame with stuff bits inserted, then 13 recessive bits.
   // fld selects the field whose first observed bit arms an STF_ERR/reset hit.
   task send_frame(input logic [3:0] fld, input logic rst);
      logic prev;
      int   run;
      ab_fld = fld; ab_rst = rst; arm = 1'b0; aborted = 1'b0; in_stream = 1'b1;
      foreach (cnt[k]) cnt[k] = 0;
      skip_cnt = 0; done_cnt = 0; fstf0 = 0; n_stuff = 0; done_at = -1;
      dcount = 0; tcount = 0; nbits = bits.size();
      at4_skip = 1'bx; at5_skip = 1'bx; at5_biten = 1'bx; at5_field = 3'bx;
      prev = 1'b1; run = 0;
      for (int i = 0; i < nbits; i++) begin
         if (aborted) break;
         drive_one(bits[i]);
         run  = (bits[i] == prev) ? run + 1 : 1;
         prev = bits[i];
         if (run == 5 && !aborted) begin
            drive_one(~prev);
            n_stuff++;
            prev = ~prev;
            run  = 1;
         end
      end
      in_stream = 1'b0;
      arm       = 1'b0;
      for (int t = 0; t < 13; t++) begin
         tcount = t;
         drive_one(1'b1);
      end
      bits.delete();
   endtask

   initial begin
      reset = 1'b1; RX = 1'b0; STF_ERR = 1'b1;
      arm = 1'b0; ab_rst = 1'b0; in_stream = 1'b0; ab_fld = 4'hF;
      repeat (2) @(posedge SP);
      #1;
      check("rst_field", {29'd0, FIELD}, 32'd0);
      check("rst_fstf", {31'd0, F_STF}, 32'd1);
      check("rst_biten", {31'd0, BIT_EN}, 32'd0);
      check("rst_skip", {31'd0, STF_SKIP}, 32'd0);
      check("rst_dlc", {28'd0, DLC}, 32'd0);
      check("rst_ide", {31'd0, IDE}, 32'd0);
      check("rst_done", {31'd0, FRAME_DONE}, 32'd0);
      @(negedge SP);
      reset = 1'b0; RX = 1'b1;
      repeat (3) @(posedge SP);

      // A: standard ID 0x123, DLC 1, data 0xAA
      build_std(11'h123, 1'b0, 4'd1, 1, 64'hAA, 15'h1234);
      send_frame(4'hF, 1'b0);
      check("A_arb", cnt[1], 12);
      check("A_ctrl", cnt[2], 6);
      check("A_data", cnt[3], 8);
      check("A_crc", cnt[4], 15);
      check("A_tail", cnt[5], 10);
      check("A_done_cnt", done_cnt, 1);
      check("A_done_at", done_at, 9);
      check("A_dlc", {28'd0, DLC}, 32'd1);
      check("A_skips", skip_cnt, n_stuff);
      check("A_fstf0", fstf0, nbits + n_stuff);

      // B: ID 0, DLC 0, CRC ending in five zeros (stuff after last CRC bit)
      build_std(11'h000, 1'b0, 4'd0, 0, 64'd0, 15'h7860);
      send_frame(4'hF, 1'b0);
      check("B_skip_bit6", {31'd0, at5_skip}, 32'd1);
      check("B_biten_bit6", {31'd0, at5_biten}, 32'd0);
      check("B_field_bit6", {29'd0, at5_field}, 32'd1);
      check("B_skip_bit5", {31'd0, at4_skip}, 32'd0);
      check("B_skips", skip_cnt, 4);
      check("B_fstf0", fstf0, 38);
      check("B_data", cnt[3], 0);
      check("B_crc", cnt[4], 15);
      check("B_tail", cnt[5], 10);
      check("B_done_cnt", done_cnt, 1);

      // C: DLC 15 capped to 8 bytes
      build_std(11'h5A5, 1'b0, 4'd15, 8, 64'h0123456789ABCDEF, 15'h2AAA);
      send_frame(4'hF, 1'b0);
      check("C_data", cnt[3], 64);
      check("C_dlc", {28'd0, DLC}, 32'd15);
      check("C_done_cnt", done_cnt, 1);
      check("C_skips", skip_cnt, n_stuff);

      // D: remote frame, DLC 4 -> no data field
      build_std(11'h321, 1'b1, 4'd4, 0, 64'd0, 15'h0F0F);
      send_frame(4'hF, 1'b0);
      check("D_data", cnt[3], 0);
      check("D_crc", cnt[4], 15);
      check("D_dlc", {28'd0, DLC}, 32'd4);
      check("D_done_cnt", done_cnt, 1);

      // E: stuff error during DATA
      build_std(11'h123, 1'b0, 4'd1, 1, 64'hAA, 15'h1234);
      send_frame(4'd3, 1'b0);
      check("E_field", {29'd0, ab_field}, 32'd0);
      check("E_fstf", {31'd0, ab_fstf}, 32'd1);
      check("E_biten", {31'd0, ab_biten}, 32'd0);
      check("E_done_cnt", done_cnt, 0);
      check("E_idle_after", {29'd0, FIELD}, 32'd0);

      // F: reset while in CRC
      build_std(11'h5A5, 1'b0, 4'd15, 8, 64'h0123456789ABCDEF, 15'h2AAA);
      send_frame(4'd4, 1'b1);
      check("F_field", {29'd0, ab_field}, 32'd0);
      check("F_fstf", {31'd0, ab_fstf}, 32'd1);
      check("F_biten", {31'd0, ab_biten}, 32'd0);
      check("F_skip", {31'd0, ab_skip}, 32'd0);
      check("F_dlc", {28'd0, ab_dlc}, 32'd0);
      check("F_ide", {31'd0, ab_ide}, 32'd0);
      check("F_done", {31'd0, ab_done}, 32'd0);
      check("F_done_cnt", done_cnt, 0);

      // G: extended frame
      build_ext(11'h155, 18'h2AAAA, 4'd2, 2, 64'hBEEF, 15'h1357);
      send_frame(4'hF, 1'b0);
`ifdef STUFF_EXT_ID_EN
      check("G_arb", cnt[1], 32);
      check("G_ctrl", cnt[2], 6);
      check("G_data", cnt[3], 16);
      check("G_ide", {31'd0, IDE}, 32'd1);
      check("G_done_cnt", done_cnt, 1);
`else
      check("G_arb", cnt[1], 12);
      check("G_ctrl", cnt[2], 0);
      check("G_ide", {31'd0, IDE}, 32'd0);
      check("G_fstf_after", {31'd0, F_STF}, 32'd1);
      check("G_done_cnt", done_cnt, 0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/stuff_window_ctrl.md
STUFF_WINDOW_CTRL -- requirements
Module: stuff_window_ctrl

Interface
REQ-001 SHALL have parameter TAIL_BITS, default 10: recessive bits after CRC before return to IDLE (CRC delim + ACK + ACK delim + EOF).
REQ-002 SHALL have parameter MAX_BYTES, default 8: data-byte cap applied to DLC.
REQ-003 SP  input  1  sample-point clock; all logic on posedge SP; one clock only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 RX  input  1  bus bit sampled at SP.
REQ-006 STF_ERR  input  1  active-low stuff-error flag from the stuff checker.
REQ-007 F_STF  output  1  active-low stuff-area flag driven to the stuff checker.
REQ-008 STF_SKIP  output  1  current bit is a stuff bit.
REQ-009 BIT_EN  output  1  current bit is a destuffed frame bit.
REQ-010 FIELD  output  3  field code of current bit: IDLE, ARB, CTRL, DATA, CRC, TAIL.
REQ-011 DLC  output  4  latched data length code.
REQ-012 IDE  output  1  latched identifier-extension bit.
REQ-013 FRAME_DONE  output  1  one-cycle pulse, end of frame.

Function
REQ-014 All outputs SHALL be registered; values after SP edge k describe the bit sampled at edge k.
REQ-015 States SHALL be IDLE, ARB, CTRL, DATA, CRC, TAIL; FIELD equals current state code.
REQ-016 IDLE: RX=0 SHALL be taken as SOF -> ARB, BIT_EN=1, run counter=1, previous bit=0.
REQ-017 In ARB..CRC, if run counter==5 the bit SHALL be a stuff bit: STF_SKIP=1, BIT_EN=0, field counter held, run counter=1, previous bit=RX.
REQ-018 Otherwise RX==previous -> run counter+1, else run counter=1; BIT_EN=1; field counter+1.
REQ-019 ARB SHALL hold 12 destuffed bits standard (ID[10:0], RTR) or 32 extended (ID_A, SRR, IDE, ID_B, RTR); IDE bit (13th) SHALL select length and latch IDE.
REQ-020 CTRL SHALL hold 6 destuffed bits (IDE/r1, r0, DLC[3:0]) standard, 6 (r1, r0, DLC) extended; DLC latched MSB first.
REQ-021 DATA length SHALL be 8*min(DLC,MAX_BYTES) bits, 0 if RTR=1; zero length SHALL go CTRL -> CRC directly.
REQ-022 CRC SHALL hold 15 destuffed bits; F_STF=0 from SOF through the last CRC bit, 1 otherwise.
REQ-023 TAIL SHALL count TAIL_BITS bits without stuff processing (STF_SKIP=0, BIT_EN=1), then -> IDLE with FRAME_DONE=1 on that edge.
REQ-024 STF_ERR=0 at any edge SHALL abort to IDLE, F_STF=1, no FRAME_DONE.
REQ-025 Stuff bit at the 5-run boundary of the last CRC bit SHALL still be consumed before TAIL.

Reset
REQ-026 reset=1 SHALL force IDLE, F_STF=1, STF_SKIP=0, BIT_EN=0, FIELD=IDLE, DLC=0, IDE=0, FRAME_DONE=0, counters 0, overriding all other inputs including mid-frame.

Configuration
REQ-027 With STUFF_EXT_ID_EN defined, extended frames SHALL be decoded per REQ-019/020.
REQ-028 Without STUFF_EXT_ID_EN, IDE=1 SHALL abort to IDLE with F_STF=1 and IDE output held 0.

Structure
REQ-029 State encoding, FIELD codes, field lengths (12, 32, 6, 15) SHALL live in package can_pkg.
REQ-030 Run counter/previous-bit logic SHALL be sub-module stuff_run_cnt (outputs stuff flag).

Verification
REQ-031 Std frame ID=0x123, DLC=1, data 0xAA -> FIELD sequence ARB(12) CTRL(6) DATA(8) CRC(15) TAIL(10), FRAME_DONE once, DLC=1.
REQ-032 ID=0x000 (SOF + 5 zeros) -> STF_SKIP=1 on 6th bit after SOF start, field counter unchanged that cycle.
REQ-033 STF_ERR=0 during DATA -> IDLE next edge, F_STF=1, no FRAME_DONE.
REQ-034 DLC=15 -> 64 data bits; RTR=1 DLC=4 -> 0 data bits.
REQ-035 reset=1 mid-CRC -> all outputs at REQ-026 values next edge.
REQ-036 Extended frame with/without STUFF_EXT_ID_EN -> 32-bit ARB vs abort at IDE bit.
